// File: rtl/axi_write_buffer.sv
// axi_write_buffer: posted-store buffer between the d_cache and an AXI write port.
// It queues uncached single-word stores and issues them one at a time as
// single-beat AXI writes. An entry leaves the buffer only when its write
// response arrives. chk_hit lets a later uncached load detect a pending store
// to the same word.
//
// Ports:
//   aclk, aresetn                              clock, async active-low reset
//   req_valid/req_ready, req_addr/size/wstrb/wdata   store request from d_cache
//   chk_addr -> chk_hit (combinational)        word-address hazard probe
//   empty                                      nothing buffered or in flight
//   aw* / w* / b*                              AXI write master channels
module axi_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter logic [3:0]  WB_ID = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    input  logic [31:0] chk_addr,
    output logic        chk_hit,
    output logic        empty,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, RESP} state_e;

    logic [31:0] addr_mem [DEPTH];
    logic [2:0]  size_mem [DEPTH];
    logic [3:0]  strb_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic          push, pop;

    // Response ID/status carry no information for a single-outstanding posted write.
    logic unused_ok;
    assign unused_ok = ^{bid, bresp, chk_addr[1:0]};

    assign req_ready = (count_q < DEPTH_C);
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == RESP) && bvalid && bready_q;
    assign empty     = (count_q == '0);

    // Entry storage; contents need no reset since count gates their use.
    always_ff @(posedge aclk) begin
        if (push) begin
            addr_mem[tail_q] <= req_addr;
            size_mem[tail_q] <= req_size;
            strb_mem[tail_q] <= req_wstrb;
            data_mem[tail_q] <= req_wdata;
        end
    end

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = pop  ? PW'(head_q + PW'(1)) : head_q;
        tail_d  = push ? PW'(tail_q + PW'(1)) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = CW'(count_q + CW'(1));
            2'b01:   count_d = CW'(count_q - CW'(1));
            default: count_d = count_q;
        endcase
    end

    // Issue FSM: raise both channels, retire each independently, then await B.
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d   = SEND;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            SEND: begin
                if (awvalid_q) begin
                    if (awready) begin
                        awvalid_d = 1'b0;
                        aw_done_d = 1'b1;
                    end
                end else if (!aw_done_q) begin
                    awvalid_d = 1'b1;
                end
                if (wvalid_q) begin
                    if (wready) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end
                end else if (!w_done_q) begin
                    wvalid_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = RESP;
                    bready_d = 1'b1;
                end
            end
            RESP: begin
                if (bvalid) begin
                    state_d  = IDLE;
                    bready_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Word-address match against every occupied slot, head included.
    always_comb begin
        logic [PW-1:0] idx;
        chk_hit = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = PW'(head_q + PW'(i));
            if ((CW'(i) < count_q) && (addr_mem[idx][31:2] == chk_addr[31:2])) begin
                chk_hit = 1'b1;
            end
        end
    end

    // Head entry drives both channels; head only moves at B, keeping payload stable.
    assign awid    = WB_ID;
    assign awaddr  = addr_mem[head_q];
    assign awlen   = 8'd0;
    assign awsize  = size_mem[head_q];
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = awvalid_q;
    assign wid     = WB_ID;
    assign wdata   = data_mem[head_q];
    assign wstrb   = strb_mem[head_q];
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: tb/tb_axi_write_buffer.sv
// Bench for axi_write_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based model of buffered stores and AXI ordering.
module tb_axi_write_buffer;

    localparam int unsigned DEPTH = 4;
    localparam logic [3:0]  WB_ID = 4'd1;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_wdata, chk_addr;
    logic [2:0]  req_size;
    logic [3:0]  req_wstrb;
    logic        chk_hit, empty;
    logic [3:0]  awid, wid, bid, wstrb, awcache;
    logic [31:0] awaddr, wdata;
    logic [7:0]  awlen;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock, bresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi_write_buffer #(.DEPTH(DEPTH), .WB_ID(WB_ID)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .empty(empty),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strb;
        logic [31:0] data;
    } st_t;

    st_t mdl[$];   // stores accepted and not yet retired by B
    st_t aw_q[$];  // stores whose AW has not yet been seen
    st_t w_q[$];   // stores whose W has not yet been seen
    int n_checks = 0, n_pass = 0;
    int aw_hs_n = 0, w_hs_n = 0, b_n = 0;
    int aw_mode = 0, w_mode = 0, b_mode = 0;  // 0 hold low, 1 always ready, 2 random
    logic        prev_aw_pend = 1'b0, prev_w_pend = 1'b0;
    logic [34:0] prev_aw = '0;
    logic [35:0] prev_w = '0;

    // AXI slave responder, updated 2 time units after each rising edge.
    always @(posedge aclk) begin
        #2;
        awready = (aw_mode == 2) ? 1'($urandom_range(0, 1)) : (aw_mode == 1);
        wready  = (w_mode == 2) ? 1'($urandom_range(0, 1)) : (w_mode == 1);
        bvalid  = bready && ((b_mode == 1) || ((b_mode == 2) && ($urandom_range(0, 2) == 0)));
        bid     = 4'($urandom);
        bresp   = 2'($urandom);
    end

    // Continuous model check on the falling edge, then record the coming edge's handshakes.
    always @(negedge aclk) begin
        if (!aresetn) begin
            mdl.delete(); aw_q.delete(); w_q.delete();
            aw_hs_n = 0; w_hs_n = 0; b_n = 0;
            prev_aw_pend = 1'b0; prev_w_pend = 1'b0;
        end else begin
            logic exp_hit;
            exp_hit = 1'b0;
            foreach (mdl[i]) if (mdl[i].addr[31:2] == chk_addr[31:2]) exp_hit = 1'b1;

            n_checks++;
            if (req_ready !== (mdl.size() < DEPTH))
                $display("FAIL mon_req_ready t=%0t got %b want %b", $time, req_ready, mdl.size() < DEPTH);
            else n_pass++;
            n_checks++;
            if (empty !== (mdl.size() == 0))
                $display("FAIL mon_empty t=%0t got %b want %b", $time, empty, mdl.size() == 0);
            else n_pass++;
            n_checks++;
            if (chk_hit !== exp_hit)
                $display("FAIL mon_chk_hit t=%0t addr %h got %b want %b", $time, chk_addr, chk_hit, exp_hit);
            else n_pass++;
            n_checks++;
            if (bready !== ((aw_hs_n - b_n == 1) && (w_hs_n - b_n == 1)))
                $display("FAIL mon_bready t=%0t got %b want %b", $time, bready,
                         (aw_hs_n - b_n == 1) && (w_hs_n - b_n == 1));
            else n_pass++;
            if (awvalid || wvalid) begin
                n_checks++;
                if ((aw_hs_n - b_n) + (w_hs_n - b_n) > ((awvalid && wvalid) ? 0 : 1))
                    $display("FAIL mon_outstanding t=%0t got aw %0d w %0d want single write",
                             $time, aw_hs_n - b_n, w_hs_n - b_n);
                else n_pass++;
            end
            if (prev_aw_pend) begin
                n_checks++;
                if ({awvalid, awaddr, awsize} !== {1'b1, prev_aw})
                    $display("FAIL mon_aw_stable t=%0t got %b/%h want 1/%h", $time, awvalid, {awaddr, awsize}, prev_aw);
                else n_pass++;
            end
            if (prev_w_pend) begin
                n_checks++;
                if ({wvalid, wdata, wstrb} !== {1'b1, prev_w})
                    $display("FAIL mon_w_stable t=%0t got %b/%h want 1/%h", $time, wvalid, {wdata, wstrb}, prev_w);
                else n_pass++;
            end

            if (awvalid && awready) begin
                n_checks++;
                if (aw_q.size() == 0)
                    $display("FAIL mon_aw_order t=%0t got AW %h want none", $time, awaddr);
                else if ({awaddr, awsize, awid, awlen, awburst, awlock, awcache, awprot} !==
                         {aw_q[0].addr, aw_q[0].size, WB_ID, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0})
                    $display("FAIL mon_aw_fields t=%0t got %h/%h/%h/%h want %h/%h/%h/00", $time,
                             awaddr, awsize, awid, awlen, aw_q[0].addr, aw_q[0].size, WB_ID);
                else n_pass++;
                if (aw_q.size() != 0) void'(aw_q.pop_front());
                aw_hs_n++;
            end
            if (wvalid && wready) begin
                n_checks++;
                if (w_q.size() == 0)
                    $display("FAIL mon_w_order t=%0t got W %h want none", $time, wdata);
                else if ({wdata, wstrb, wid, wlast} !== {w_q[0].data, w_q[0].strb, WB_ID, 1'b1})
                    $display("FAIL mon_w_fields t=%0t got %h/%h/%h/%b want %h/%h/%h/1", $time,
                             wdata, wstrb, wid, wlast, w_q[0].data, w_q[0].strb, WB_ID);
                else n_pass++;
                if (w_q.size() != 0) void'(w_q.pop_front());
                w_hs_n++;
            end
            if (bvalid && bready) begin
                n_checks++;
                if (mdl.size() == 0) $display("FAIL mon_b_pop t=%0t got B want none", $time);
                else begin n_pass++; void'(mdl.pop_front()); end
                b_n++;
            end
            if (req_valid && req_ready) begin
                st_t s;
                s = '{addr: req_addr, size: req_size, strb: req_wstrb, data: req_wdata};
                mdl.push_back(s); aw_q.push_back(s); w_q.push_back(s);
            end
            prev_aw_pend = awvalid && !awready;
            prev_aw      = {awaddr, awsize};
            prev_w_pend  = wvalid && !wready;
            prev_w       = {wdata, wstrb};
        end
    end

    task automatic step();
        @(posedge aclk); #1;
    endtask

    // Offer one store once req_ready is seen; returns one step after the push edge.
    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int n = 0; n < 300 && !req_ready; n++) step();
        req_addr = a; req_wdata = d; req_wstrb = s; req_size = 3'd2;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_empty(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            if (empty) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic wait_awvalid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (awvalid) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({awvalid, wvalid, bready, req_ready, empty, chk_hit} !== 6'b000110)
            $display("FAIL reset_state got %b want 000110", {awvalid, wvalid, bready, req_ready, empty, chk_hit});
        else n_pass++;
        step(); step();
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_single();
        bit ok;
        aw_mode = 1; w_mode = 1; b_mode = 1;
        req_addr = 32'h1FAF_0004; req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF; req_size = 3'd2;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n_checks++;
        if ({awvalid, wvalid} !== 2'b00) $display("FAIL single_lat1 got %b want 00", {awvalid, wvalid});
        else n_pass++;
        step();
        n_checks++;
        if ({awvalid, wvalid} !== 2'b00) $display("FAIL single_lat2 got %b want 00", {awvalid, wvalid});
        else n_pass++;
        step();
        n_checks++;
        if ({awvalid, wvalid, awaddr, wdata} !== {2'b11, 32'h1FAF_0004, 32'hDEAD_BEEF})
            $display("FAIL single_issue got %b %h %h want 11 1faf0004 deadbeef", {awvalid, wvalid}, awaddr, wdata);
        else n_pass++;
        step();
        n_checks++;
        if ({awvalid, wvalid, bready, empty} !== 4'b0010)
            $display("FAIL single_resp got %b want 0010", {awvalid, wvalid, bready, empty});
        else n_pass++;
        step();
        n_checks++;
        if ({bready, empty} !== 2'b01) $display("FAIL single_empty got %b want 01", {bready, empty});
        else n_pass++;
        wait_empty(20, ok);
    endtask

    task automatic test_fill();
        bit ok;
        int b0;
        aw_mode = 0; w_mode = 0; b_mode = 1;
        for (int i = 0; i < 4; i++) push_store(32'h2000_0000 + 32'(i * 4), $urandom, 4'($urandom));
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL fill_full got %b want 0", req_ready);
        else n_pass++;
        step(); step();
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL fill_hold got %b want 0", req_ready);
        else n_pass++;
        aw_mode = 1; w_mode = 1;
        b0 = b_n;
        for (int n = 0; n < 30 && b_n == b0; n++) step();
        n_checks++;
        if (req_ready !== 1'b1 || b_n == b0) $display("FAIL fill_after_pop got %b want 1", req_ready);
        else n_pass++;
        wait_empty(100, ok);
        n_checks++;
        if (!ok) $display("FAIL fill_drain got empty %b want 1", empty);
        else n_pass++;
    endtask

    task automatic test_skew();
        bit ok;
        logic [31:0] wd;
        aw_mode = 0; w_mode = 0; b_mode = 1;
        push_store(32'h3000_0010, 32'hA5A5_1234, 4'h3);
        wait_awvalid(ok);
        wd = wdata;
        w_mode = 1;
        step();
        w_mode = 0;
        n_checks++;
        if ({ok, awvalid, wvalid, bready, wdata} !== {4'b1100, wd})
            $display("FAIL skew_w_done got %b %h want 1100 %h", {ok, awvalid, wvalid, bready}, wdata, wd);
        else n_pass++;
        step();
        n_checks++;
        if ({awvalid, wvalid, bready, wdata} !== {3'b100, wd})
            $display("FAIL skew_wait2 got %b %h want 100 %h", {awvalid, wvalid, bready}, wdata, wd);
        else n_pass++;
        step();
        aw_mode = 1;
        n_checks++;
        if ({awvalid, bready} !== 2'b10) $display("FAIL skew_wait3 got %b want 10", {awvalid, bready});
        else n_pass++;
        step();
        n_checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) $display("FAIL skew_aw_done got %b want 001", {awvalid, wvalid, bready});
        else n_pass++;
        wait_empty(20, ok);
        n_checks++;
        if (!ok) $display("FAIL skew_drain got empty %b want 1", empty);
        else n_pass++;
    endtask

    task automatic test_hazard();
        bit ok;
        aw_mode = 0; w_mode = 0; b_mode = 1;
        push_store(32'h1FAF_F008, 32'h1111_2222, 4'hF);
        chk_addr = 32'h1FAF_F00B; #1;
        n_checks++;
        if (chk_hit !== 1'b1) $display("FAIL hazard_hit got %b want 1", chk_hit);
        else n_pass++;
        chk_addr = 32'h1FAF_F00C; #1;
        n_checks++;
        if (chk_hit !== 1'b0) $display("FAIL hazard_miss got %b want 0", chk_hit);
        else n_pass++;
        chk_addr = 32'h1FAF_F008;
        step();
        aw_mode = 1; w_mode = 1;
        wait_empty(30, ok);
        n_checks++;
        if ({ok, chk_hit} !== 2'b10) $display("FAIL hazard_retired got %b want 10", {ok, chk_hit});
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        aw_mode = 0; w_mode = 0; b_mode = 1;
        for (int i = 0; i < 3; i++) push_store(32'h4000_0000 + 32'(i * 4), $urandom, 4'($urandom));
        aw_mode = 1; w_mode = 1;
        for (int n = 0; n < 30 && !bready; n++) step();
        aw_mode = 0; w_mode = 0;
        push_store(32'h4000_000C, $urandom, 4'($urandom));  // lands on the same edge as the pop
        n_checks++;
        if ({req_ready, empty} !== 2'b10) $display("FAIL wrap_concurrent got %b want 10", {req_ready, empty});
        else n_pass++;
        push_store(32'h4000_0010, $urandom, 4'($urandom));
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL wrap_count3_plus1 got %b want 0", req_ready);
        else n_pass++;
        aw_mode = 2; w_mode = 2; b_mode = 2;
        for (int i = 5; i < 10; i++) begin
            push_store(32'h4000_0000 + 32'(i * 4), $urandom, 4'($urandom));
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
        wait_empty(400, ok);
        n_checks++;
        if ({ok, b_n} !== {1'b1, 32'(b_n)} || aw_q.size() != 0 || w_q.size() != 0)
            $display("FAIL wrap_drain got empty %b aw_left %0d want 1 0", empty, aw_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        int b0;
        b0 = b_n;
        aw_mode = 2; w_mode = 2; b_mode = 2;
        for (int i = 0; i < 40; i++) begin
            chk_addr = 32'h5000_0000 + 32'($urandom_range(0, 15) * 2);
            push_store(32'h5000_0000 + 32'($urandom_range(0, 7) * 4), $urandom, 4'($urandom));
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
        end
        wait_empty(1000, ok);
        n_checks++;
        if (!ok || (b_n - b0) != 40) $display("FAIL random_drain got %0d B want 40", b_n - b0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        aw_mode = 0; w_mode = 0; b_mode = 1;
        push_store(32'h6000_0020, 32'hCAFE_F00D, 4'hF);
        push_store(32'h6000_0024, 32'hBEEF_0001, 4'hF);
        wait_awvalid(ok);
        chk_addr = 32'h6000_0020;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({ok, awvalid, wvalid, bready, req_ready, empty, chk_hit} !== 7'b1000110)
            $display("FAIL reset_mid got %b want 1000110", {ok, awvalid, wvalid, bready, req_ready, empty, chk_hit});
        else n_pass++;
        step(); step();
        aresetn = 1'b1;
        aw_mode = 1; w_mode = 1;
        step(); step(); step(); step();
        n_checks++;
        if ({awvalid, wvalid, bready, empty} !== 4'b0001)
            $display("FAIL reset_no_resume got %b want 0001", {awvalid, wvalid, bready, empty});
        else n_pass++;
    endtask

    initial begin
        req_valid = 1'b0; req_addr = '0; req_size = 3'd2; req_wstrb = '0; req_wdata = '0;
        chk_addr = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        test_reset();
        test_single();
        test_fill();
        test_skew();
        test_hazard();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_write_buffer.md
AXI_WRITE_BUFFER -- requirements
Module: axi_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of buffered store entries (power of two, 2..8).
REQ-002 Parameter WB_ID, default 4'd1, is the AXI ID driven on awid and wid.
REQ-003 aclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  d_cache offers an uncached single-word store.
REQ-006 req_ready  out  1  buffer can accept the store this cycle.
REQ-007 req_addr  in  32, req_size  in  3, req_wstrb  in  4, req_wdata  in  32  store address, size, byte strobes, data.
REQ-008 chk_addr  in  32  address probed by d_cache before an uncached load.
REQ-009 chk_hit  out  1  combinational; a buffered entry matches chk_addr[31:2].
REQ-010 empty  out  1  no entry buffered or in flight.
REQ-011 awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1, awready  in  1  AXI write-address master.
REQ-012 wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1, wready  in  1  AXI write-data master.
REQ-013 bid  in  4, bresp  in  2, bvalid  in  1, bready  out  1  AXI write-response master.

Function
REQ-014 FIFO of DEPTH entries {addr, size, wstrb, wdata}, with wrapping head/tail pointers and a count of width clog2(DEPTH)+1.
REQ-015 req_ready = (count < DEPTH), registered-state only, no bypass; a push occurs when req_valid && req_ready.
REQ-016 Entry popped only at B handshake (bvalid && bready); a simultaneous push and pop leaves count unchanged.
REQ-017 Issue FSM states: IDLE, SEND, RESP.
REQ-018 IDLE -> SEND when count != 0; awvalid and wvalid both rise in the cycle after entry into SEND, driven from the head entry.
REQ-019 SEND keeps per-channel done flags; awvalid drops after the awready handshake, wvalid drops after the wready handshake, independently; AW and W handshakes may occur in either order or in the same cycle.
REQ-020 SEND -> RESP once both handshakes have completed; bready = 1 only in RESP.
REQ-021 RESP -> IDLE on bvalid; head is popped in the same cycle; bid and bresp are ignored.
REQ-022 Only one AXI write is outstanding at a time; the minimum latency from push to awvalid in an empty buffer is 2 cycles.
REQ-023 awaddr, awsize, wdata and wstrb stay stable while their valid is high and unacknowledged.
REQ-024 Fixed fields: awlen = 0, awburst = 2'b01, awlock = 0, awcache = 0, awprot = 0, wlast = 1, awid = wid = WB_ID.
REQ-025 chk_hit covers all count entries, including the in-flight head, and compares bits [31:2] only.
REQ-026 empty = (count == 0); this implies FSM IDLE.
REQ-027 When full, req_ready = 0 until the cycle after a pop; the wrap of head/tail past DEPTH-1 returns them to 0.

Reset
REQ-028 Reset clears count, head and tail, returns the FSM to IDLE, and drives awvalid = wvalid = bready = 0, req_ready = 1, empty = 1 and chk_hit = 0; entry contents are don't-care.
REQ-029 Reset mid-transaction abandons the outstanding AXI write; no resume occurs after reset.

Verification
REQ-030 Single store: push addr 0x1FAF_0004, data 0xDEADBEEF, strb 4'hF, size 2; awready = wready = 1 -> awvalid and wvalid high 2 cycles later with awaddr 0x1FAF_0004 and wdata 0xDEADBEEF; bvalid 3 cycles later -> empty = 1 next cycle.
REQ-031 Fill: push 4 stores with awready held 0 -> req_ready = 0 after the 4th push; one B completes -> req_ready = 1 next cycle, and the AXI order equals the push order.
REQ-032 Channel skew: wready at cycle +1 and awready at cycle +4 -> wvalid drops after cycle +1, bready rises only after the AW handshake, and wdata is unchanged throughout.
REQ-033 Hazard: buffer holds 0x1FAF_F008; chk_addr 0x1FAF_F00B -> chk_hit = 1; chk_addr 0x1FAF_F00C -> chk_hit = 0; after its B -> chk_hit = 0.
REQ-034 Wrap and concurrency: push 10 stores with a simultaneous push/pop at count = 3 -> count stays 3, all 10 issue in order, and the pointers wrap correctly.
REQ-035 Reset during SEND: assert aresetn = 0 while awvalid = 1 -> awvalid, wvalid and bready are 0 immediately; empty = 1.
